multiplication: RTL and testbench

Sequential shift-add fixed-point multiplier: the inverse of the division datapath. It accepts an unsigned Q10.10 operand (the quotient format the divider emits) and a 3-bit unsigned multiplier, and returns the full-precision product. The operand protocol is the same as the divider's: a burst on in_valid, then a single-cycle out_valid pulse. It is used to reconstruct dividends from quotients and for self-checking division results.

---
 rtl/multiplication.sv | 126 ++++++++++++
 tb/tb_multiplication.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/multiplication.sv
// Sequential shift-add multiplier: unsigned Q10.10 multiplicand times a small unsigned integer,
// one multiplier bit per cycle. Define MULT_ROUND_EN to round the product half-up to an integer.
module multiplication #(
  parameter int WIDTH_A = 20,
  parameter int WIDTH_B = 3,
  parameter int FRAC    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH_A-1:0]         in_data_1,
  input  logic [WIDTH_B-1:0]         in_data_2,
  output logic                       out_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] out_data
);

  localparam int WIDTH_P = WIDTH_A + WIDTH_B;
  localparam int IDX_W   = (WIDTH_B > 1) ? $clog2(WIDTH_B) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH_B - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MULT,
    DONE
  } state_t;

  state_t               state_q;
  logic [WIDTH_P-1:0]   a_q;        // multiplicand, shifted left once per MULT cycle
  logic [WIDTH_B-1:0]   b_q;        // multiplier, shifted right once per MULT cycle
  logic [IDX_W-1:0]     idx_q;
  logic [WIDTH_P-1:0]   acc_q;
  logic                 out_valid_q;
  logic [WIDTH_P-1:0]   out_data_q;

  logic [WIDTH_P-1:0]   acc_d;
  logic                 last_bit_d;
  logic [WIDTH_P-1:0]   result_d;

  // Partial sum for the current bit; the step is the last once no higher multiplier bits remain.
  always_comb begin
    acc_d      = acc_q + (b_q[0] ? a_q : '0);
    last_bit_d = ((b_q >> 1) == '0) || (idx_q == LAST_IDX);
  end

`ifdef MULT_ROUND_EN
  localparam logic [WIDTH_P:0]   HALF      = (WIDTH_P + 1)'(1) << (FRAC - 1);
  localparam logic [WIDTH_P-1:0] INT_MASK  = {{(WIDTH_P - FRAC){1'b1}}, {FRAC{1'b0}}};

  logic [WIDTH_P:0] rounded_d;

  always_comb begin
    rounded_d = {1'b0, acc_d} + HALF;
    result_d  = rounded_d[WIDTH_P] ? '1 : (rounded_d[WIDTH_P-1:0] & INT_MASK);
  end
`else
  always_comb begin
    result_d = acc_d;
  end
`endif

  // NOTE: async reset clears every register, including the datapath, so an aborted
  // operation can never leak a partial product; all state updates are non-blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            a_q     <= {{WIDTH_B{1'b0}}, in_data_1};
            b_q     <= in_data_2;
            state_q <= LOAD;
          end
        end

        LOAD: begin
          acc_q <= '0;
          idx_q <= '0;
          if (in_valid) begin
            a_q <= {{WIDTH_B{1'b0}}, in_data_1};
            b_q <= in_data_2;
          end else begin
            state_q <= MULT;
          end
        end

        MULT: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          idx_q <= idx_q + 1'b1;
          if (last_bit_d) begin
            out_data_q  <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          out_valid_q <= 1'b0;
          if (in_valid) begin
            a_q     <= {{WIDTH_B{1'b0}}, in_data_1};
            b_q     <= in_data_2;
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for the shift-add multiplier: vector table plus burst, back-to-back and reset sequences.
module tb_multiplication;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [19:0] in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic [22:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  multiplication dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] a;
    logic [2:0]  b;
    logic [22:0] exp_exact;
    logic [22:0] exp_round;
    int          exp_cyc;
  } vec_t;

  function automatic logic [22:0] pick(input logic [22:0] exact, input logic [22:0] rnd);
`ifdef MULT_ROUND_EN
    return rnd;
`else
    return exact;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One burst cycle: operands are sampled on the next rising edge.
  task automatic apply(input logic [19:0] a, input logic [2:0] b);
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    @(posedge clk); #1;
  endtask

  // Called #1 after the edge that starts cycle 0; watches 10 cycles for the result pulse.
  task automatic measure(input string name, input logic [22:0] exp, input int exp_cyc);
    int first = -1;
    int cnt   = 0;
    logic [22:0] seen = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) begin
          first = c;
          seen  = out_data;
        end
        cnt++;
      end
    end
    check({name, " pulse cycle"}, first, exp_cyc);
    check({name, " pulse width"}, cnt, 1);
    check({name, " data"}, seen, exp);
    check({name, " data hold"}, out_data, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t vecs[8];
    int   c;
    int   pulses;

    vecs[0] = '{20'h00C00, 3'd5, 23'h003C00, 23'h003C00, 4};
    vecs[1] = '{20'h12345, 3'd0, 23'h000000, 23'h000000, 2};
    vecs[2] = '{20'h12345, 3'd1, 23'h012345, 23'h012400, 2};
    vecs[3] = '{20'hFFFFF, 3'd7, 23'h6FFFF9, 23'h700000, 4};
    vecs[4] = '{20'h00A00, 3'd1, 23'h000A00, 23'h000C00, 2};
    vecs[5] = '{20'h00900, 3'd1, 23'h000900, 23'h000800, 2};
    vecs[6] = '{20'h00001, 3'd4, 23'h000004, 23'h000000, 4};
    vecs[7] = '{20'h00100, 3'd6, 23'h000600, 23'h000800, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    #3;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      measure($sformatf("vec%0d", i), pick(vecs[i].exp_exact, vecs[i].exp_round), vecs[i].exp_cyc);
    end

    // Three-cycle burst: only the last pair counts; a new burst starts in the DONE cycle.
    apply(20'h00100, 3'd3);
    apply(20'h00200, 3'd6);
    apply(20'h00400, 3'd2);
    in_valid = 1'b0;
    c = 0;
    while (c < 10) begin
      @(negedge clk);
      if (out_valid) break;
      c++;
    end
    check("burst pulse cycle", c, 3);
    check("burst data", out_data, pick(23'h000800, 23'h000800));
    in_valid  = 1'b1;
    in_data_1 = 20'h00400;
    in_data_2 = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    measure("b2b", pick(23'h000C00, 23'h000C00), 3);

    // Reset in the middle of MULT discards the partial product.
    apply(20'hFFFFF, 3'd7);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", out_valid, 0);
    check("midreset out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midreset no pulse", pulses, 0);
    @(posedge clk); #1;
    apply(20'h00C00, 3'd5);
    in_valid = 1'b0;
    measure("after reset", pick(23'h003C00, 23'h003C00), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
